// File: rtl/cache_pkg.sv
// Shared types and load/store lane helpers for the N-way data cache.
// Latency: pure combinational functions, no state.
// Backpressure: none; callers own all flow control.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } cache_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  boff);
        logic [7:0]  b;
        logic [15:0] h;
        case (boff)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        // Half-word select ignores addr[0]: halves never straddle a word.
        h = boff[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    load_extract = {{24{b[7]}}, b};
            F3_H:    load_extract = {{16{h[15]}}, h};
            F3_BU:   load_extract = {24'd0, b};
            F3_HU:   load_extract = {16'd0, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  boff);
        logic [31:0] res;
        res = old_word;
        case (f3)
            F3_B: begin
                case (boff)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    default: res[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (boff[1]) res[31:16] = wdata[15:0];
                else         res[15:0]  = wdata[15:0];
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dcache_plru.sv
// Tree-PLRU for one set: next-tree after touching a way, and current victim.
// Latency: combinational.
// Backpressure: none.
module dcache_plru #(
    parameter  int WAYS = 2,
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [PW-1:0] tree,
    input  logic [WW-1:0] access_way,
    output logic [PW-1:0] tree_next,
    output logic [WW-1:0] victim
);

    generate
        if (WAYS == 1) begin : g_direct
            logic unused_in;
            assign unused_in = ^{tree, access_way};
            assign tree_next = '0;
            assign victim    = '0;
        end else begin : g_tree
            localparam int LVL = $clog2(WAYS);

            // Node n has children 2n+1 (left, bit=0) and 2n+2 (right, bit=1);
            // each bit points toward the subtree holding the next victim.
            always_comb begin
                int node;
                tree_next = tree;
                node      = 0;
                for (int l = 0; l < LVL; l++) begin
                    tree_next[node] = ~access_way[LVL-1-l];
                    node = 2 * node + 1 + int'(access_way[LVL-1-l]);
                end
            end

            always_comb begin
                int node;
                node = 0;
                for (int l = 0; l < LVL; l++) begin
                    node = 2 * node + 1 + int'(tree[node]);
                end
                victim = WW'(node - (WAYS - 1));
            end
        end
    endgenerate

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative write-back data cache with tree-PLRU replacement.
// Latency: hits complete in the request cycle; misses cost memory cycles + 1.
// Backpressure: stall holds the core on a miss until the line is installed.
module dcache_nway
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAYS        = 2,
    parameter int SETS        = 16,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rd_en,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [2:0]                        funct3,
    input  logic [DATA_WIDTH-1:0]             WriteData,
    output logic [DATA_WIDTH-1:0]             ReadData,
    output logic                              stall,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_wdata,
    input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_rdata,
    input  logic                              mem_ready
);

    localparam int OFF  = $clog2(BLOCK_WORDS * 4);
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = ADDR_WIDTH - IDX - OFF;
    localparam int LINE = BLOCK_WORDS * DATA_WIDTH;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int WSW  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    logic [TAG-1:0]  tag_q   [SETS][WAYS];
    logic [LINE-1:0] data_q  [SETS][WAYS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [PW-1:0]   plru_q  [SETS];

    cache_state_t    state_q, state_d;
    logic [TAG-1:0]  miss_tag_q;
    logic [IDX-1:0]  miss_idx_q;
    logic [WW-1:0]   vict_q;

    logic [TAG-1:0]        req_tag;
    logic [IDX-1:0]        req_idx;
    logic [1:0]            boff;
    logic [WSW-1:0]        word_sel;
    logic                  req, idle, hit, access_hit, miss, fill;
    logic [WW-1:0]         hit_way, vict_d, plru_victim, fill_victim_unused;
    logic [PW-1:0]         plru_hit_next, plru_fill_next;
    logic [DATA_WIDTH-1:0] cur_word;

    assign req_tag  = addr[ADDR_WIDTH-1 -: TAG];
    assign req_idx  = addr[OFF +: IDX];
    assign boff     = addr[1:0];
    assign word_sel = (BLOCK_WORDS > 1) ? addr[2 +: WSW] : '0;

    assign req        = rd_en | wr_en;
    assign idle       = (state_q == IDLE);
    assign access_hit = idle && req && hit;
    assign miss       = idle && req && !hit;
    assign fill       = (state_q == REFILL) && mem_ready;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Lowest-index invalid way wins over the PLRU choice.
    always_comb begin
        vict_d = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) vict_d = WW'(w);
        end
    end

    dcache_plru #(.WAYS(WAYS)) u_plru_hit (
        .tree       (plru_q[req_idx]),
        .access_way (hit_way),
        .tree_next  (plru_hit_next),
        .victim     (plru_victim)
    );

    dcache_plru #(.WAYS(WAYS)) u_plru_fill (
        .tree       (plru_q[miss_idx_q]),
        .access_way (vict_q),
        .tree_next  (plru_fill_next),
        .victim     (fill_victim_unused)
    );

    assign cur_word = data_q[req_idx][hit_way][word_sel*DATA_WIDTH +: DATA_WIDTH];

    // rst gates the combinational outputs so they read zero while held in reset.
    assign stall    = !rst && (!idle || (req && !hit));
    assign ReadData = (!rst && access_hit && !wr_en) ? load_extract(cur_word, funct3, boff) : '0;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[miss_idx_q][vict_q], miss_idx_q, {OFF{1'b0}}};
                mem_wdata = data_q[miss_idx_q][vict_q];
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag_q, miss_idx_q, {OFF{1'b0}}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = (valid_q[req_idx][vict_d] && dirty_q[req_idx][vict_d])
                              ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: if (mem_ready) state_d = REFILL;
            REFILL:    if (mem_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            vict_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (miss) begin
                miss_tag_q <= req_tag;
                miss_idx_q <= req_idx;
                vict_q     <= vict_d;
            end
            if (access_hit) begin
                plru_q[req_idx] <= plru_hit_next;
                if (wr_en) dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (fill) begin
                valid_q[miss_idx_q][vict_q] <= 1'b1;
                dirty_q[miss_idx_q][vict_q] <= 1'b0;
                plru_q[miss_idx_q]          <= plru_fill_next;
            end
        end
    end

    // Payload arrays carry no reset; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (access_hit && wr_en) begin
            data_q[req_idx][hit_way][word_sel*DATA_WIDTH +: DATA_WIDTH] <=
                store_merge(cur_word, WriteData, funct3, boff);
        end
        if (fill) begin
            data_q[miss_idx_q][vict_q] <= mem_rdata;
            tag_q[miss_idx_q][vict_q]  <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway (WAYS=2, SETS=16, BLOCK_WORDS=4): hits, misses,
// dirty write-back, clean replacement, sub-word accesses and reset mid-refill.
module tb_dcache_nway;
    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en, wr_en;
    logic [31:0]  addr;
    logic [2:0]   funct3;
    logic [31:0]  WriteData;
    logic [31:0]  ReadData;
    logic         stall, mem_req, mem_we, mem_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] LINE_A    = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    localparam logic [127:0] LINE_A_WB = {32'h33333333, 32'h22222222, 32'h11111111, 32'hBEEF80EF};
    localparam logic [127:0] LINE_B    = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    localparam logic [127:0] LINE_C    = {32'h33330003, 32'h33330002, 32'h33330001, 32'h30303030};

    dcache_nway #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .WAYS(2), .SETS(16), .BLOCK_WORDS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .addr      (addr),
        .funct3    (funct3),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] wd);
        rd_en     = rd;
        wr_en     = wr;
        addr      = a;
        funct3    = f3;
        WriteData = wd;
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        drive(1'b0, 1'b0, 32'h0, F3_W, 32'h0);
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", ReadData, 0);
        @(negedge clk); rst = 1'b0;

        // Cold miss on 0x100, memory answers on the third refill cycle.
        @(negedge clk); drive(1'b1, 1'b0, 32'h100, F3_W, 32'h0); #1;
        chk("t1_miss_stall", stall, 1);
        chk("t1_idle_no_req", mem_req, 0);
        @(negedge clk); mem_rdata = LINE_A; #1;
        chk("t1_refill_req", mem_req, 1);
        chk("t1_refill_we", mem_we, 0);
        chk("t1_refill_addr", mem_addr, 32'h100);
        chk("t1_refill_stall", stall, 1);
        @(negedge clk); #1;
        chk("t1_wait_req", mem_req, 1);
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("t1_ready_stall", stall, 1);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("t1_hit_stall", stall, 0);
        chk("t1_hit_data", ReadData, 32'hDEADBEEF);
        chk("t1_idle_req", mem_req, 0);

        // Byte store then signed / unsigned byte loads.
        @(negedge clk); drive(1'b0, 1'b1, 32'h101, F3_B, 32'h00000080); #1;
        chk("t2_sb_stall", stall, 0);
        @(negedge clk); drive(1'b1, 1'b0, 32'h101, F3_BU, 32'h0); #1;
        chk("t2_lbu", ReadData, 32'h00000080);
        funct3 = F3_B; #1;
        chk("t2_lb", ReadData, 32'hFFFFFF80);
        addr = 32'h100; funct3 = F3_W; #1;
        chk("t2_lw_merged", ReadData, 32'hDEAD80EF);

        // Half store into the upper half, then assorted sub-word loads.
        @(negedge clk); drive(1'b0, 1'b1, 32'h102, F3_H, 32'h1234BEEF); #1;
        chk("t6_sh_stall", stall, 0);
        @(negedge clk); drive(1'b1, 1'b0, 32'h100, F3_W, 32'h0); #1;
        chk("t6_lw", ReadData, 32'hBEEF80EF);
        addr = 32'h102; funct3 = F3_H; #1;
        chk("t6_lh", ReadData, 32'hFFFFBEEF);
        addr = 32'h103; funct3 = F3_HU; #1;
        chk("t6_lhu_odd", ReadData, 32'h0000BEEF);
        addr = 32'h100; funct3 = F3_BU; #1;
        chk("t6_lbu0", ReadData, 32'h000000EF);
        addr = 32'h104; funct3 = F3_W; #1;
        chk("t6_lw_word1", ReadData, 32'h11111111);
        addr = 32'h100; funct3 = 3'b011; #1;
        chk("t6_other_f3", ReadData, 32'hBEEF80EF);

        // Stray mem_ready while idle must be ignored.
        @(negedge clk); drive(1'b0, 1'b0, 32'h0, F3_W, 32'h0); mem_ready = 1'b1; #1;
        chk("t6_stray_req", mem_req, 0);
        chk("t6_stray_stall", stall, 0);
        @(negedge clk); mem_ready = 1'b0; drive(1'b1, 1'b0, 32'h100, F3_W, 32'h0); #1;
        chk("t6_after_stray_stall", stall, 0);
        chk("t6_after_stray_data", ReadData, 32'hBEEF80EF);

        // Fill 0x200 into way 1 (same set), then 0x300 evicts dirty 0x100.
        @(negedge clk); drive(1'b1, 1'b0, 32'h200, F3_W, 32'h0); mem_rdata = LINE_B; #1;
        chk("t3_200_stall", stall, 1);
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("t3_200_addr", mem_addr, 32'h200);
        chk("t3_200_we", mem_we, 0);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("t3_200_stall_done", stall, 0);
        chk("t3_200_data", ReadData, 32'hA0A0A0A0);
        @(negedge clk); drive(1'b1, 1'b0, 32'h300, F3_W, 32'h0); #1;
        chk("t3_300_stall", stall, 1);
        @(negedge clk); #1;
        chk("t3_wb_req", mem_req, 1);
        chk("t3_wb_we", mem_we, 1);
        chk("t3_wb_addr", mem_addr, 32'h100);
        chk("t3_wb_data", mem_wdata, LINE_A_WB);
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("t3_wb_hold_addr", mem_addr, 32'h100);
        chk("t3_wb_hold_data", mem_wdata, LINE_A_WB);
        @(negedge clk); mem_ready = 1'b0; mem_rdata = LINE_C; #1;
        chk("t3_refill_we", mem_we, 0);
        chk("t3_refill_addr", mem_addr, 32'h300);
        chk("t3_refill_stall", stall, 1);
        @(negedge clk); mem_ready = 1'b1; #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("t3_300_hit_stall", stall, 0);
        chk("t3_300_data", ReadData, 32'h30303030);
        addr = 32'h204; #1;
        chk("t3_200_still", ReadData, 32'hA1A1A1A1);
        chk("t3_200_still_stall", stall, 0);

        // 0x100 returns: PLRU now picks clean 0x300, so no write-back.
        @(negedge clk); drive(1'b1, 1'b0, 32'h100, F3_W, 32'h0); mem_rdata = LINE_A_WB; #1;
        chk("t4_stall", stall, 1);
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("t4_no_wb_we", mem_we, 0);
        chk("t4_refill_addr", mem_addr, 32'h100);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("t4_data", ReadData, 32'hBEEF80EF);

        // Reset in the middle of a refill.
        @(negedge clk); drive(1'b1, 1'b0, 32'h300, F3_W, 32'h0); mem_rdata = LINE_C; #1;
        chk("t5_stall", stall, 1);
        @(negedge clk); #1;
        chk("t5_refill_req", mem_req, 1);
        chk("t5_refill_addr", mem_addr, 32'h300);
        @(negedge clk); rst = 1'b1; #1;
        chk("t5_rst_req", mem_req, 0);
        chk("t5_rst_stall", stall, 0);
        chk("t5_rst_rdata", ReadData, 0);
        @(negedge clk); rst = 1'b0; drive(1'b1, 1'b0, 32'h100, F3_W, 32'h0); mem_rdata = LINE_A_WB; #1;
        chk("t5_remiss_stall", stall, 1);
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("t5_remiss_we", mem_we, 0);
        chk("t5_remiss_addr", mem_addr, 32'h100);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("t5_remiss_data", ReadData, 32'hBEEF80EF);
        chk("t5_remiss_done", stall, 0);

        @(negedge clk); drive(1'b0, 1'b0, 32'h0, F3_W, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
